// File: rtl/byte_serial_alu_ctrl_if.sv
// byte_serial_alu_ctrl_if: request/result bundle between the execute stage and the byte-serial ALU sequencer.
interface byte_serial_alu_ctrl_if #(parameter int NBYTES = 4);
  localparam int W = 8 * NBYTES;
  logic         start;
  logic         op_sub;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic         ready;
  logic         busy;
  logic         result_valid;
  logic [W-1:0] data_result;
  logic         cout;
  logic         overflow;
  modport master (
    output start, op_sub, data_operandA, data_operandB,
    input  ready, busy, result_valid, data_result, cout, overflow
  );
  modport slave (
    input  start, op_sub, data_operandA, data_operandB,
    output ready, busy, result_valid, data_result, cout, overflow
  );
endinterface

// File: rtl/byte_serial_alu_ctrl.sv
// byte_serial_alu_ctrl: wide add/subtract computed LSB-first by one shared 8-bit carry-lookahead adder.
module addmodule (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout
);
  logic [7:0] w_g;
  logic [7:0] w_p;
  logic [8:0] w_c;
  // Each carry is a flat sum of generate terms gated by the propagates above them.
  function automatic logic lookahead(input logic [7:0] g, input logic [7:0] p, input logic cin, input int n);
    logic acc;
    logic pp;
    acc = 1'b0;
    pp = 1'b1;
    for (int j = n - 1; j >= 0; j--) begin
      acc = acc | (g[j] & pp);
      pp = pp & p[j];
    end
    return acc | (pp & cin);
  endfunction
  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;
  assign w_c[0] = i_cin;
  for (genvar i = 0; i < 8; i++) begin : g_c
    assign w_c[i+1] = lookahead(w_g, w_p, i_cin, i + 1);
  end
  assign o_sum = w_p ^ w_c[7:0];
  assign o_cout = w_c[8];
endmodule

module byte_serial_alu_ctrl #(parameter int NBYTES = 4) (
  input logic i_clock,
  input logic i_reset_n,
  byte_serial_alu_ctrl_if.slave bus
);
  localparam int W = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0]  r_opa, r_opb, r_res;
  logic          r_carry, r_cout, r_ovf;
  logic [IW-1:0] r_idx;
  logic [7:0]    w_a, w_b, w_sum;
  logic          w_co, w_accept, w_last;
  assign w_a = r_opa[{r_idx, 3'b000} +: 8];
  assign w_b = r_opb[{r_idx, 3'b000} +: 8];
  addmodule u_add (.i_a(w_a), .i_b(w_b), .i_cin(r_carry), .o_sum(w_sum), .o_cout(w_co));
  assign w_accept = (r_state == IDLE) && bus.start;
  assign w_last = r_idx == LAST;
  always_comb begin
    w_next = IDLE;
    w_next = (r_state == IDLE) ? (bus.start ? RUN : IDLE) :
             (r_state == RUN)  ? (w_last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state <= IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_idx   <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_opa   <= bus.data_operandA;
        r_opb   <= bus.op_sub ? ~bus.data_operandB : bus.data_operandB;
        r_carry <= bus.op_sub;
        r_idx   <= '0;
        r_res   <= '0;
        r_cout  <= 1'b0;
        r_ovf   <= 1'b0;
      end else if (r_state == RUN) begin
        r_res[{r_idx, 3'b000} +: 8] <= w_sum;
        r_carry <= w_co;
        r_idx   <= w_last ? '0 : r_idx + 1'b1;
        if (w_last) begin
          r_cout <= w_co;
          r_ovf  <= (r_opa[W-1] == r_opb[W-1]) && (w_sum[7] != r_opa[W-1]);
        end
      end
    end
  end
  assign bus.ready        = r_state == IDLE;
  assign bus.busy         = r_state != IDLE;
  assign bus.result_valid = r_state == DONE;
  assign bus.data_result  = r_res;
  assign bus.cout         = r_cout;
  assign bus.overflow     = r_ovf;
endmodule

// File: tb/tb_byte_serial_alu_ctrl.sv
// tb_byte_serial_alu_ctrl: randomized and directed checks of the byte-serial ALU against an arithmetic model.
module tb_byte_serial_alu_ctrl;
  localparam int NB = 4;
  localparam int W = 8 * NB;
  logic clk = 1'b0;
  logic rst_n;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  byte_serial_alu_ctrl_if #(.NBYTES(NB)) bus ();
  byte_serial_alu_ctrl #(.NBYTES(NB)) dut (.i_clock(clk), .i_reset_n(rst_n), .bus(bus));

  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    logic [W:0] full;
    logic [W-1:0] r;
    logic o;
    full = sub ? ({1'b0, a} + {1'b0, ~b} + (W+1)'(1)) : ({1'b0, a} + {1'b0, b});
    r = full[W-1:0];
    o = sub ? ((a[W-1] != b[W-1]) && (r[W-1] != a[W-1])) : ((a[W-1] == b[W-1]) && (r[W-1] != a[W-1]));
    return {o, full[W], r};
  endfunction

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub, input string name);
    logic [W+1:0] exp;
    int cyc;
    exp = model(a, b, sub);
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin errors++; $display("FAIL %s ready_before got=%b exp=1", name, bus.ready); end
    bus.start = 1'b1; bus.data_operandA = a; bus.data_operandB = b; bus.op_sub = sub;
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL %s ready_drop got ready=%b busy=%b exp 0/1", name, bus.ready, bus.busy); end
    cyc = 1;
    while (bus.result_valid !== 1'b1 && cyc < 20) begin @(negedge clk); cyc++; end
    checks++;
    if (cyc !== NB + 1) begin errors++; $display("FAIL %s latency got=%0d exp=%0d", name, cyc, NB + 1); end
    checks++;
    if ({bus.overflow, bus.cout, bus.data_result} !== exp)
      begin errors++; $display("FAIL %s result got ovf=%b cout=%b res=%h exp ovf=%b cout=%b res=%h", name,
        bus.overflow, bus.cout, bus.data_result, exp[W+1], exp[W], exp[W-1:0]); end
    @(negedge clk);
    checks++;
    if (bus.result_valid !== 1'b0 || bus.ready !== 1'b1 || bus.data_result !== exp[W-1:0])
      begin errors++; $display("FAIL %s after_pulse got rv=%b ready=%b res=%h exp 0/1/%h", name,
        bus.result_valid, bus.ready, bus.data_result, exp[W-1:0]); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op_sub = 1'b0; bus.data_operandA = '0; bus.data_operandB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.ready, bus.busy, bus.result_valid, bus.cout, bus.overflow} !== 5'b10000 || bus.data_result !== '0)
      begin errors++; $display("FAIL reset got rdy=%b busy=%b rv=%b cout=%b ovf=%b res=%h exp 1/0/0/0/0/0",
        bus.ready, bus.busy, bus.result_valid, bus.cout, bus.overflow, bus.data_result); end
    rst_n = 1'b1;
  endtask

  task automatic test_add_timing();
    run_op(32'h000000FF, 32'h00000001, 1'b0, "add_timing");
  endtask

  task automatic test_corners();
    logic [W-1:0] ca [5] = '{32'h00000000, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h12345678};
    logic [W-1:0] cb [5] = '{32'h00000001, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, 32'h12345678};
    logic         cs [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) run_op(ca[i], cb[i], cs[i], $sformatf("corner%0d", i));
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
  endtask

  task automatic test_ignored_start();
    int pulses;
    logic [W-1:0] res;
    pulses = 0;
    res = '0;
    @(negedge clk);
    bus.start = 1'b1; bus.op_sub = 1'b0; bus.data_operandA = 32'h01020304; bus.data_operandB = 32'h10101010;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1; bus.data_operandA = 32'h11111111;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (bus.result_valid === 1'b1) begin pulses++; res = bus.data_result; end
      @(negedge clk);
    end
    checks++;
    if (pulses !== 1) begin errors++; $display("FAIL ignored_start pulses got=%0d exp=1", pulses); end
    checks++;
    if (res !== 32'h11121314) begin errors++; $display("FAIL ignored_start result got=%h exp=11121314", res); end
    checks++;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b1) begin errors++; $display("FAIL ignored_start idle got busy=%b ready=%b exp 0/1", bus.busy, bus.ready); end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    pulses = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op_sub = 1'b0; bus.data_operandA = 32'h01020304; bus.data_operandB = 32'h10101010;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({bus.ready, bus.busy, bus.result_valid, bus.cout, bus.overflow} !== 5'b10000 || bus.data_result !== '0)
      begin errors++; $display("FAIL reset_mid_run got rdy=%b busy=%b rv=%b cout=%b ovf=%b res=%h exp 1/0/0/0/0/0",
        bus.ready, bus.busy, bus.result_valid, bus.cout, bus.overflow, bus.data_result); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.result_valid === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin errors++; $display("FAIL reset_mid_run pulses got=%0d exp=0", pulses); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a2, b2;
    logic [W+1:0] e1, e2;
    logic [W+1:0] got [$];
    int acc [$];
    a2 = W'($urandom);
    b2 = W'($urandom);
    e1 = model(32'hCAFEF00D, 32'h0BADBEEF, 1'b0);
    e2 = model(a2, b2, 1'b1);
    @(negedge clk);
    bus.start = 1'b1; bus.op_sub = 1'b0; bus.data_operandA = 32'hCAFEF00D; bus.data_operandB = 32'h0BADBEEF;
    for (int c = 0; c < 30 && got.size() < 2; c++) begin
      if (bus.ready === 1'b1 && got.size() == 1) begin
        checks++;
        if (bus.data_result !== e1[W-1:0]) begin errors++; $display("FAIL b2b hold got=%h exp=%h", bus.data_result, e1[W-1:0]); end
      end
      if (bus.ready === 1'b1 && bus.start === 1'b1) acc.push_back(c);
      if (bus.result_valid === 1'b1) begin
        got.push_back({bus.overflow, bus.cout, bus.data_result});
        bus.op_sub = 1'b1; bus.data_operandA = a2; bus.data_operandB = b2;
        if (got.size() == 2) bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    checks++;
    if (got.size() !== 2 || acc.size() < 2) begin
      errors++; $display("FAIL b2b count got results=%0d accepts=%0d exp 2/2", got.size(), acc.size());
    end else begin
      checks++;
      if (acc[1] - acc[0] !== NB + 2) begin errors++; $display("FAIL b2b spacing got=%0d exp=%0d", acc[1] - acc[0], NB + 2); end
      checks++;
      if (got[0] !== e1) begin errors++; $display("FAIL b2b first got=%h exp=%h", got[0], e1); end
      checks++;
      if (got[1] !== e2) begin errors++; $display("FAIL b2b second got=%h exp=%h", got[1], e2); end
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_corners();
    test_random();
    test_ignored_start();
    test_reset_mid_run();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
